// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage constants and tag types for the physical free list.
// Other rename blocks use preg_t in place of hard 6-bit tags.
package phys_free_list_pkg;
  localparam int ARCH_REGS    = 32;
  localparam int PHYS_REGS    = 48;
  localparam int RENAME_PORTS = 2;
  localparam int COMMIT_PORTS = 2;

  localparam int DEPTH  = PHYS_REGS - ARCH_REGS;
  localparam int PREG_W = $clog2(PHYS_REGS);
  localparam int AREG_W = 5;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int APC_W  = $clog2(RENAME_PORTS + 1);
  localparam int FPC_W  = $clog2(COMMIT_PORTS + 1);

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [CNT_W:0]    sum_t;
endpackage

// File: rtl/phys_free_list_if.sv
// Rename/commit-side bundle of the physical free list.
interface phys_free_list_if;
  import phys_free_list_pkg::*;

  logic [RENAME_PORTS-1:0] alloc_req;
  logic                    alloc_gnt;
  preg_t                   alloc_phys [RENAME_PORTS];
  logic [COMMIT_PORTS-1:0] free_en;
  preg_t                   free_phys [COMMIT_PORTS];
  logic                    flush_pipeline;
  cnt_t                    free_count;
  logic                    overflow_err;

  modport master (
    output alloc_req, free_en, free_phys, flush_pipeline,
    input  alloc_gnt, alloc_phys, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, free_en, free_phys, flush_pipeline,
    output alloc_gnt, alloc_phys, free_count, overflow_err
  );
endinterface

// File: rtl/phys_free_list_prefix_popcount.sv
// Exclusive prefix population count: prefix[j] = popcount(bits[j-1:0]).
module prefix_popcount #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] prefix [N],
  output logic [CW-1:0] total
);
  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int j = 0; j < N; j++) begin
      prefix[j] = acc;
      acc       = acc + CW'(bits[j]);
    end
    total = acc;
  end
endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with a committed head so a flush
// restores speculative allocation state in one cycle.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  phys_free_list_if.slave bus
);
  preg_t entry [DEPTH];
  ptr_t  spec_head, commit_head, tail;
  cnt_t  spec_count;
  logic  overflow_q;

  logic [APC_W-1:0] alloc_pre [RENAME_PORTS];
  logic [APC_W-1:0] alloc_n;
  logic [FPC_W-1:0] free_pre [COMMIT_PORTS];
  logic [FPC_W-1:0] free_n;

  cnt_t n_ext, granted;
  sum_t count_sum;
  logic would_overflow;

  function automatic ptr_t wrap_add(ptr_t p, cnt_t inc);
    int s;
    s = int'(p) + int'(inc);
    if (s >= DEPTH) s = s - DEPTH;
    return s[PTR_W-1:0];
  endfunction

  prefix_popcount #(.N(RENAME_PORTS), .CW(APC_W)) u_alloc_pc (
    .bits   (bus.alloc_req),
    .prefix (alloc_pre),
    .total  (alloc_n)
  );

  prefix_popcount #(.N(COMMIT_PORTS), .CW(FPC_W)) u_free_pc (
    .bits   (bus.free_en),
    .prefix (free_pre),
    .total  (free_n)
  );

  // Grant sees only the registered count: same-cycle frees are not bypassed.
  always_comb begin
    n_ext         = cnt_t'(alloc_n);
    bus.alloc_gnt = (n_ext <= spec_count) && !bus.flush_pipeline;
    for (int j = 0; j < RENAME_PORTS; j++)
      bus.alloc_phys[j] = entry[wrap_add(spec_head, cnt_t'(alloc_pre[j]))];
    granted        = bus.alloc_gnt ? n_ext : '0;
    count_sum      = {1'b0, spec_count} - {1'b0, granted} + sum_t'(free_n);
    would_overflow = count_sum > sum_t'(DEPTH);
  end

  assign bus.free_count   = spec_count;
  assign bus.overflow_err = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= preg_t'(ARCH_REGS + i);
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      spec_count  <= cnt_t'(DEPTH);
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < COMMIT_PORTS; i++)
        if (bus.free_en[i])
          entry[wrap_add(tail, cnt_t'(free_pre[i]))] <= bus.free_phys[i];
      tail        <= wrap_add(tail, cnt_t'(free_n));
      commit_head <= wrap_add(commit_head, cnt_t'(free_n));
      // Every commit pairs one consume with one free, so the committed count is always DEPTH.
      if (bus.flush_pipeline) begin
        spec_head  <= wrap_add(commit_head, cnt_t'(free_n));
        spec_count <= cnt_t'(DEPTH);
      end else begin
        if (bus.alloc_gnt) spec_head <= wrap_add(spec_head, n_ext);
        spec_count <= count_sum[CNT_W-1:0];
        if (would_overflow) overflow_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < COMMIT_PORTS; i++) begin : g_free_chk
    a_no_zero_free: assert property (@(posedge clk) disable iff (reset)
      bus.free_en[i] |-> (bus.free_phys[i] != '0));
  end

  for (genvar j = 0; j < RENAME_PORTS; j++) begin : g_alloc_chk
    a_no_zero_alloc: assert property (@(posedge clk) disable iff (reset)
      (bus.alloc_gnt && bus.alloc_req[j]) |-> (bus.alloc_phys[j] != '0));
  end
endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: directed table, corner sequences, and random traffic
// against a queue-based model of the committed free list.
module tb_phys_free_list;
  import phys_free_list_pkg::*;

  logic clk = 1'b0;
  logic reset;

  phys_free_list_if bus();

  phys_free_list dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // mlist: committed free list in order (front = oldest); the first mk entries are speculatively handed out.
  int mlist[$];
  int owned[$];
  int mk;

  logic last_gnt;
  int   last_cnt;
  int   last_tag [2];

  typedef struct {
    logic [1:0] req;
    logic [1:0] fen;
    int         fp0;
    int         fp1;
    logic       flush;
    logic       exp_gnt;
    int         exp_p0;
    int         exp_p1;
    int         exp_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(logic [1:0] req, logic [1:0] fen, int fp0, int fp1, logic flush,
                               logic eg, int ep0, int ep1, int ec);
    vec_t v;
    v.req = req; v.fen = fen; v.fp0 = fp0; v.fp1 = fp1; v.flush = flush;
    v.exp_gnt = eg; v.exp_p0 = ep0; v.exp_p1 = ep1; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mlist.delete();
    owned.delete();
    for (int i = 0; i < DEPTH; i++) mlist.push_back(ARCH_REGS + i);
    for (int i = 1; i < ARCH_REGS; i++) owned.push_back(i);
    mk = 0;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] fen, input int fp0, input int fp1,
                       input logic flush);
    bus.alloc_req      = req;
    bus.free_en        = fen;
    bus.free_phys[0]   = preg_t'(fp0);
    bus.free_phys[1]   = preg_t'(fp1);
    bus.flush_pipeline = flush;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 1, 1, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, sample mid-cycle, compare to model, advance model across the edge.
  task automatic step(input logic [1:0] req, input logic [1:0] fen, input int fp0, input int fp1,
                      input logic flush);
    int   avail, n, k;
    int   fps [2];
    logic exp_gnt;
    fps[0] = fp0; fps[1] = fp1;
    drive(req, fen, fp0, fp1, flush);
    @(negedge clk);
    avail   = mlist.size() - mk;
    n       = int'(req[0]) + int'(req[1]);
    exp_gnt = !flush && (n <= avail);
    last_gnt = bus.alloc_gnt;
    last_cnt = int'(bus.free_count);
    chk("alloc_gnt", int'(bus.alloc_gnt), int'(exp_gnt));
    chk("free_count", int'(bus.free_count), avail);
    k = 0;
    for (int j = 0; j < 2; j++) begin
      last_tag[j] = int'(bus.alloc_phys[j]);
      if (req[j]) begin
        if (exp_gnt) chk($sformatf("alloc_phys[%0d]", j), int'(bus.alloc_phys[j]), mlist[mk + k]);
        k++;
      end
    end
    if (exp_gnt) mk += n;
    for (int i = 0; i < 2; i++) begin
      if (fen[i]) begin
        owned.push_back(mlist.pop_front());
        mlist.push_back(fps[i]);
        mk--;
      end
    end
    if (flush) mk = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("reset overflow_err", int'(bus.overflow_err), 0);

    // Drain, free-without-bypass, and all-or-nothing grant.
    for (int i = 0; i < 8; i++)
      vt.push_back(mkv(2'b11, 2'b00, 1, 1, 1'b0, 1'b1, 32 + 2*i, 33 + 2*i, 16 - 2*i));
    vt.push_back(mkv(2'b11, 2'b00, 1, 1, 1'b0, 1'b0, -1, -1, 0));
    vt.push_back(mkv(2'b01, 2'b01, 5, 1, 1'b0, 1'b0, -1, -1, 0));
    vt.push_back(mkv(2'b01, 2'b00, 1, 1, 1'b0, 1'b1, 5, -1, 1));
    vt.push_back(mkv(2'b00, 2'b01, 6, 1, 1'b0, 1'b1, -1, -1, 0));
    vt.push_back(mkv(2'b11, 2'b00, 1, 1, 1'b0, 1'b0, -1, -1, 1));
    vt.push_back(mkv(2'b10, 2'b00, 1, 1, 1'b0, 1'b1, -1, 6, 1));
    vt.push_back(mkv(2'b00, 2'b00, 1, 1, 1'b0, 1'b1, -1, -1, 0));

    for (int v = 0; v < vt.size(); v++) begin
      step(vt[v].req, vt[v].fen, vt[v].fp0, vt[v].fp1, vt[v].flush);
      chk($sformatf("vec%0d gnt", v), int'(last_gnt), int'(vt[v].exp_gnt));
      chk($sformatf("vec%0d count", v), last_cnt, vt[v].exp_cnt);
      if (vt[v].exp_p0 >= 0) chk($sformatf("vec%0d phys0", v), last_tag[0], vt[v].exp_p0);
      if (vt[v].exp_p1 >= 0) chk($sformatf("vec%0d phys1", v), last_tag[1], vt[v].exp_p1);
    end

    // Allocate 32..37, commit two with frees 3,7, flush: list resumes at 34.
    do_reset();
    repeat (3) step(2'b11, 2'b00, 1, 1, 1'b0);
    step(2'b00, 2'b11, 3, 7, 1'b0);
    step(2'b00, 2'b00, 1, 1, 1'b1);
    chk("flush gnt", int'(last_gnt), 0);
    for (int i = 0; i < 8; i++) begin
      step(2'b11, 2'b00, 1, 1, 1'b0);
      if (i == 0) chk("post-flush count", last_cnt, 16);
      chk($sformatf("replay%0d p0", i), last_tag[0], (i < 7) ? 34 + 2*i : 3);
      chk($sformatf("replay%0d p1", i), last_tag[1], (i < 7) ? 35 + 2*i : 7);
    end

    // Flush in the same cycle as two frees.
    step(2'b11, 2'b11, 9, 10, 1'b1);
    chk("flush+free gnt", int'(last_gnt), 0);
    step(2'b11, 2'b00, 1, 1, 1'b0);
    chk("flush+free count", last_cnt, 16);
    chk("flush+free p0", last_tag[0], 36);
    chk("flush+free p1", last_tag[1], 37);

    // Reset with traffic pending.
    reset = 1'b1;
    drive(2'b11, 2'b11, 12, 13, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step(2'b01, 2'b00, 1, 1, 1'b0);
    chk("reset-mid count", last_cnt, 16);
    chk("reset-mid p0", last_tag[0], 32);
    chk("reset-mid overflow", int'(bus.overflow_err), 0);

    // Random legal traffic.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic [1:0] req, fen;
      logic       flush;
      int         fp [2];
      int         idx;
      req   = 2'($urandom_range(0, 3));
      fen   = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 15) == 0);
      if (mk == 0) fen = 2'b00;
      else if (mk == 1 && fen == 2'b11) fen = 2'b01;
      fp[0] = 1; fp[1] = 1;
      for (int i = 0; i < 2; i++) begin
        if (fen[i]) begin
          idx   = $urandom_range(0, owned.size() - 1);
          fp[i] = owned[idx];
          owned.delete(idx);
        end
      end
      step(req, fen, fp[0], fp[1], flush);
    end
    chk("final overflow_err", int'(bus.overflow_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
